interp_add1_seq: RTL and testbench
==================================

# interp_add1_seq

Microsequencer for the channel-estimation interpolation datapath: on a start pulse it steps the shared first adder through a fixed per-point operand schedule, once for each of NUM_POINTS interpolated points. It drives the 3-bit operand select of the add1 B-input mux and the load strobes of the accumulator, reg_2E and reg_5E. It presents each finished point on a valid/ready handshake and signals completion to the channel-estimation top-level control.

## Interface
- NUM_POINTS, 12, interpolated points per start; legal range 1..255
- PT_W, $clog2(NUM_POINTS) (minimum 1), width of pt_idx
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; honoured only in IDLE, ignored otherwise
- out_ready  in  1  consumer accepts the current point
- add1_b_sel  out  3  operand select: 000 = +1, 001 = 2E3, 011 = 2E4, 010 = reg_5E, 110 = E1, 100 = reg_2E, 111 = zero
- acc_clr  out  1  clear accumulator before the add
- acc_en  out  1  accumulator captures the adder output
- reg2e_ld  out  1  load reg_2E from the datapath (−2E3 form)
- reg5e_ld  out  1  load reg_5E from the datapath
- out_valid  out  1  accumulator holds a finished point
- pt_idx  out  PT_W  index of the point being computed, 0..NUM_POINTS−1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last point is accepted

## Operation
- Moore FSM: state register plus point counter. All outputs decode from registered state only; no input-to-output combinational path.
- States: IDLE, C0, C1, C2, C3, C4, C5, DONE.
- Per-state outputs (unlisted strobes are 0):
  - IDLE: add1_b_sel = 111
  - C0: sel = 000, acc_clr = 1, acc_en = 1
  - C1: sel = 001, acc_en = 1, reg2e_ld = 1
  - C2: sel = 100, acc_en = 1
  - C3: sel = 011, acc_en = 1, reg5e_ld = 1
  - C4: sel = 010, acc_en = 1
  - C5: sel = 110, acc_en only on the first C5 cycle, out_valid = 1
  - DONE: sel = 111, done = 1
- Transitions:
  - IDLE →start→ C0, with pt_idx cleared to 0.
  - C0 → C1 → C2 → C3 → C4 → C5, unconditionally, one cycle each.
  - C5 with out_ready = 1: if pt_idx = NUM_POINTS−1 go to DONE, else increment pt_idx and go to C0.
  - C5 with out_ready = 0: stay in C5, out_valid held, acc_en low so the accumulator is not re-added.
  - DONE → IDLE unconditionally.
- In C5, acc_en is high only on the first cycle. A 1-bit "c5_first" flag, set on entry to C5, tracks this.
- pt_idx holds its last value in DONE and IDLE until the next start.
- A start pulse while busy = 1 is dropped, not queued.
- NUM_POINTS = 1: C5 accept goes directly to DONE.

## Timing
- Reset value of every output: add1_b_sel = 111, pt_idx = 0, all 1-bit outputs 0; state = IDLE. Reset assertion mid-sequence aborts at once with no done pulse.
- Start sampled at edge t → C0 and busy = 1 from t+1.
- With out_ready tied high: 6 cycles per point. First out_valid at t+6; last out_valid at t+6·NUM_POINTS; done at t+6·NUM_POINTS+1; IDLE at the following cycle.
- Each cycle of out_ready = 0 in C5 adds exactly one cycle of latency.
- out_valid/out_ready transfer completes on an edge where both are high.
- start arriving on the same edge that DONE → IDLE is ignored. The earliest accepted start is the first edge in IDLE.

## Configuration
- INTERP_ROUND_EN defined: C0 exists as above, adding the +1 rounding operand; 6 cycles per point.
- INTERP_ROUND_EN undefined:
  - C0 is not built; acc_clr moves to C1, so C1 drives sel = 001 with acc_clr = 1, acc_en = 1, reg2e_ld = 1.
  - IDLE → C1, and C5 → C1 for the next point.
  - 5 cycles per point; all latencies above use 5 in place of 6.

## Test plan
- Reset mid-run: rst during C3 of point 4 → all outputs at reset values at once, no done; next start restarts at pt_idx = 0.
- Nominal run: NUM_POINTS = 12, out_ready = 1, start at t → sel sequence 000, 001, 100, 011, 010, 110 repeated 12×; 12 out_valid pulses with pt_idx 0..11; done at t+73; busy high from t+1 to t+73.
- Backpressure: out_ready = 0 for 3 cycles at point 5 → C5 held 4 cycles, acc_en high only on the first; done at t+76.
- Start while busy: start pulses at t+10 and at the DONE cycle → ignored; exactly one done pulse.
- NUM_POINTS = 1: start at t → one out_valid at t+6, done at t+7.
- INTERP_ROUND_EN undefined, NUM_POINTS = 12: sel 000 never appears; done at t+61.

Source files
------------

// File: rtl/interp_add1_seq_if.sv
//------------------------------------------------------------------------------
// interp_add1_seq_if
//
// Purpose : Bundles the control/handshake signals between the add1
//           microsequencer and its neighbours (top-level control, the
//           interpolation datapath and the downstream point consumer).
//
// Parameter:
//   NUM_POINTS  interpolated points per start (1..255); sets pt_idx width
//
// Signals:
//   start       top control -> sequencer, one-cycle request
//   out_ready   consumer    -> sequencer, accepts the finished point
//   add1_b_sel  sequencer   -> datapath, add1 B-input operand select
//   acc_clr     sequencer   -> datapath, clear accumulator before the add
//   acc_en      sequencer   -> datapath, accumulator captures adder output
//   reg2e_ld    sequencer   -> datapath, load reg_2E
//   reg5e_ld    sequencer   -> datapath, load reg_5E
//   out_valid   sequencer   -> consumer, accumulator holds a finished point
//   pt_idx      sequencer   -> consumer, index of the current point
//   busy        sequencer   -> top control, high outside IDLE
//   done        sequencer   -> top control, one-cycle completion pulse
//
// Modports:
//   master  the sequencer side
//   slave   the surrounding control / datapath / consumer side
//------------------------------------------------------------------------------
interface interp_add1_seq_if #(
    parameter int NUM_POINTS = 12
);
    localparam int PT_W = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;

    logic            start;
    logic            out_ready;
    logic [2:0]      add1_b_sel;
    logic            acc_clr;
    logic            acc_en;
    logic            reg2e_ld;
    logic            reg5e_ld;
    logic            out_valid;
    logic [PT_W-1:0] pt_idx;
    logic            busy;
    logic            done;

    modport master (
        input  start,
        input  out_ready,
        output add1_b_sel,
        output acc_clr,
        output acc_en,
        output reg2e_ld,
        output reg5e_ld,
        output out_valid,
        output pt_idx,
        output busy,
        output done
    );

    modport slave (
        output start,
        output out_ready,
        input  add1_b_sel,
        input  acc_clr,
        input  acc_en,
        input  reg2e_ld,
        input  reg5e_ld,
        input  out_valid,
        input  pt_idx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/interp_add1_seq.sv
//------------------------------------------------------------------------------
// interp_add1_seq
//
// Purpose : Microsequencer for the channel-estimation interpolation datapath.
//           On a start pulse it walks the shared first adder (add1) through a
//           fixed operand schedule once per interpolated point, for
//           NUM_POINTS points, drives the accumulator / reg_2E / reg_5E load
//           strobes, presents each finished point on a valid/ready handshake
//           and pulses done after the last point has been accepted.
//
// Optional feature (compile-time macro INTERP_ROUND_EN):
//   defined   : a C0 step adds the +1 rounding operand; 6 cycles per point.
//   undefined : C0 is not built, the accumulator clear moves to C1;
//               5 cycles per point.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   interp_add1_seq_if.master (start, out_ready in; add1_b_sel,
//         acc_clr, acc_en, reg2e_ld, reg5e_ld, out_valid, pt_idx, busy,
//         done out)
//
// Operand select encoding (add1_b_sel):
//   000 +1, 001 2E3, 011 2E4, 010 reg_5E, 110 E1, 100 reg_2E, 111 zero
//
// All outputs are a decode of registered state only (Moore); there is no
// combinational path from start/out_ready to any output.
//------------------------------------------------------------------------------
module interp_add1_seq #(
    parameter int NUM_POINTS = 12
) (
    input  logic               clk,
    input  logic               rst,
    interp_add1_seq_if.master  bus
);
    localparam int PT_W = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;

    localparam logic [PT_W-1:0] PT_LAST = PT_W'(NUM_POINTS - 1);
    localparam logic [PT_W-1:0] PT_ONE  = PT_W'(1);

    // Operand select codes for the add1 B-input mux.
    localparam logic [2:0] SEL_ONE   = 3'b000;
    localparam logic [2:0] SEL_2E3   = 3'b001;
    localparam logic [2:0] SEL_2E4   = 3'b011;
    localparam logic [2:0] SEL_REG5E = 3'b010;
    localparam logic [2:0] SEL_E1    = 3'b110;
    localparam logic [2:0] SEL_REG2E = 3'b100;
    localparam logic [2:0] SEL_ZERO  = 3'b111;

`ifdef INTERP_ROUND_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_C0   = 3'd1,
        S_C1   = 3'd2,
        S_C2   = 3'd3,
        S_C3   = 3'd4,
        S_C4   = 3'd5,
        S_C5   = 3'd6,
        S_DONE = 3'd7
    } state_t;
    // Every point starts with the rounding step.
    localparam state_t S_FIRST = S_C0;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_C1   = 3'd2,
        S_C2   = 3'd3,
        S_C3   = 3'd4,
        S_C4   = 3'd5,
        S_C5   = 3'd6,
        S_DONE = 3'd7
    } state_t;
    // Without rounding the point starts directly with the 2E3 add.
    localparam state_t S_FIRST = S_C1;
`endif

    state_t          state_q;
    state_t          state_d;
    logic [PT_W-1:0] pt_q;
    logic [PT_W-1:0] pt_d;
    // Set on entry to C5 so the accumulator is captured exactly once per
    // point, however long the consumer stalls.
    logic            c5_first_q;
    logic            c5_first_d;

    //--------------------------------------------------------------------------
    // State, point counter and C5 first-cycle flag
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pt_q       <= '0;
            c5_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pt_q       <= pt_d;
            c5_first_q <= c5_first_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pt_d       = pt_q;
        c5_first_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // start is only looked at here, so pulses while busy drop.
                if (bus.start) begin
                    state_d = S_FIRST;
                    pt_d    = '0;
                end
            end
`ifdef INTERP_ROUND_EN
            S_C0: state_d = S_C1;
`endif
            S_C1: state_d = S_C2;
            S_C2: state_d = S_C3;
            S_C3: state_d = S_C4;
            S_C4: begin
                state_d    = S_C5;
                c5_first_d = 1'b1;
            end
            S_C5: begin
                if (bus.out_ready) begin
                    if (pt_q == PT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FIRST;
                        pt_d    = pt_q + PT_ONE;
                    end
                end
                // Stalled: remain in C5 with the flag cleared (default).
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Output decode (registered state only)
    //--------------------------------------------------------------------------
    logic [2:0] sel;
    logic       clr;
    logic       en;
    logic       ld2e;
    logic       ld5e;
    logic       vld;
    logic       fin;

    always_comb begin
        sel  = SEL_ZERO;
        clr  = 1'b0;
        en   = 1'b0;
        ld2e = 1'b0;
        ld5e = 1'b0;
        vld  = 1'b0;
        fin  = 1'b0;

        unique case (state_q)
            S_IDLE: sel = SEL_ZERO;
`ifdef INTERP_ROUND_EN
            S_C0: begin
                sel = SEL_ONE;
                clr = 1'b1;
                en  = 1'b1;
            end
            S_C1: begin
                sel  = SEL_2E3;
                en   = 1'b1;
                ld2e = 1'b1;
            end
`else
            S_C1: begin
                // First add of the point, so it also clears the accumulator.
                sel  = SEL_2E3;
                clr  = 1'b1;
                en   = 1'b1;
                ld2e = 1'b1;
            end
`endif
            S_C2: begin
                sel = SEL_REG2E;
                en  = 1'b1;
            end
            S_C3: begin
                sel  = SEL_2E4;
                en   = 1'b1;
                ld5e = 1'b1;
            end
            S_C4: begin
                sel = SEL_REG5E;
                en  = 1'b1;
            end
            S_C5: begin
                sel = SEL_E1;
                en  = c5_first_q;
                vld = 1'b1;
            end
            S_DONE: begin
                sel = SEL_ZERO;
                fin = 1'b1;
            end
            default: begin
                sel = SEL_ZERO;
            end
        endcase
    end

    assign bus.add1_b_sel = sel;
    assign bus.acc_clr    = clr;
    assign bus.acc_en     = en;
    assign bus.reg2e_ld   = ld2e;
    assign bus.reg5e_ld   = ld5e;
    assign bus.out_valid  = vld;
    assign bus.done       = fin;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.pt_idx     = pt_q;

endmodule

// File: tb/tb_interp_add1_seq.sv
`timescale 1ns/1ps
module tb_interp_add1_seq;
    localparam int N = 12;
`ifdef INTERP_ROUND_EN
    localparam int CPP = 6;
`else
    localparam int CPP = 5;
`endif

    typedef struct packed {
        logic [2:0] sel;
        logic       clr;
        logic       en;
        logic       l2e;
        logic       l5e;
        logic       valid;
        logic       busy;
        logic       done;
        logic [7:0] idx;
    } obs_t;

    typedef struct {
        logic start;
        logic ready;
        obs_t exp;
    } step_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    interp_add1_seq_if #(.NUM_POINTS(N)) bus ();
    interp_add1_seq_if #(.NUM_POINTS(1)) bus1 ();

    interp_add1_seq #(.NUM_POINTS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    interp_add1_seq #(.NUM_POINTS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int model_idx = 0;
    step_t tr[$];
    obs_t  sched[CPP-1];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic [2:0] sel, input logic clr, input logic en,
                                input logic l2e, input logic l5e, input logic valid,
                                input logic busy, input logic done, input int idx);
        obs_t o;
        o.sel = sel; o.clr = clr; o.en = en; o.l2e = l2e; o.l5e = l5e;
        o.valid = valid; o.busy = busy; o.done = done; o.idx = 8'(idx);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.sel = bus.add1_b_sel; o.clr = bus.acc_clr; o.en = bus.acc_en;
        o.l2e = bus.reg2e_ld; o.l5e = bus.reg5e_ld; o.valid = bus.out_valid;
        o.busy = bus.busy; o.done = bus.done; o.idx = 8'(bus.pt_idx);
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Operand schedule of one point before the output step (C5).
    task automatic init_sched();
`ifdef INTERP_ROUND_EN
        sched[0] = mk(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        sched[1] = mk(3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        sched[2] = mk(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        sched[3] = mk(3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        sched[4] = mk(3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
`else
        sched[0] = mk(3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        sched[1] = mk(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        sched[2] = mk(3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        sched[3] = mk(3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
`endif
    endtask

    task automatic gen_idle(input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s.start = 1'b0;
            s.ready = 1'($urandom);
            s.exp   = mk(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_idx);
            tr.push_back(s);
        end
    endtask

    // One whole start..done run: idle cycle carrying start, N points, DONE.
    // Each point stalls for a random 0..maxstall cycles, except fix_pt which
    // stalls exactly fix_n. hold_start keeps start high throughout.
    task automatic gen_run(input int maxstall, input int fix_pt, input int fix_n,
                           input bit hold_start);
        step_t s;
        int stall;
        s.start = 1'b1;
        s.ready = 1'($urandom);
        s.exp   = mk(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_idx);
        tr.push_back(s);
        for (int p = 0; p < N; p++) begin
            for (int k = 0; k < CPP - 1; k++) begin
                s.start = hold_start ? 1'b1 : 1'($urandom);
                s.ready = 1'($urandom);
                s.exp   = sched[k];
                s.exp.idx = 8'(p);
                tr.push_back(s);
            end
            stall = (p == fix_pt) ? fix_n : ((maxstall > 0) ? $urandom_range(maxstall, 0) : 0);
            for (int i = 0; i <= stall; i++) begin
                s.start = hold_start ? 1'b1 : 1'($urandom);
                s.ready = (i == stall);
                s.exp   = mk(3'b110, 1'b0, (i == 0), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, p);
                tr.push_back(s);
            end
        end
        s.start = 1'b1;  // arrives on the DONE -> IDLE edge, must be dropped
        s.ready = 1'($urandom);
        s.exp   = mk(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, N - 1);
        tr.push_back(s);
        model_idx = N - 1;
    endtask

    // Called at posedge+1: compare, drive inputs for the next edge, advance.
    task automatic apply_trace(input string name);
        for (int j = 0; j < tr.size(); j++) begin
            check(name, sample(), tr[j].exp);
            bus.start     = tr[j].start;
            bus.out_ready = tr[j].ready;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        tr.delete();
    endtask

    initial begin
        int c;
        bit seen;
        init_sched();
        rst = 1'b1;
        bus.start = 1'b0;  bus.out_ready = 1'b0;
        bus1.start = 1'b0; bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", sample(), mk(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal run, start held high throughout (busy starts must drop).
        gen_idle(1);
        gen_run(0, -1, 0, 1'b1);
        gen_idle(2);
        apply_trace("nominal");

        // Backpressure: 3 stall cycles on point 5.
        gen_run(0, 5, 3, 1'b0);
        gen_idle(1);
        apply_trace("backpressure");

        // Randomised runs, including back-to-back restarts.
        for (int r = 0; r < 4; r++) begin
            gen_run(3, -1, 0, 1'b0);
            gen_idle($urandom_range(2, 0));
        end
        gen_idle(1);
        apply_trace("random");

        // Reset during C3 of point 4.
        bus.start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus.add1_b_sel == 3'b011 && bus.pt_idx == 4) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_int("reach_pt4_c3", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        check("reset_mid_run", sample(), mk(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        @(posedge clk); #1;
        check("reset_held", sample(), mk(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_reset_idle", sample(), mk(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        model_idx = 0;
        gen_run(1, -1, 0, 1'b0);
        gen_idle(1);
        apply_trace("restart");

        // NUM_POINTS = 1 instance.
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        check_int("n1_busy", int'(bus1.busy), 1);
        c = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            if (bus1.out_valid) begin seen = 1'b1; c = i; end
            else begin @(posedge clk); #1; end
        end
        check_int("n1_valid_latency", c, CPP);
        check_int("n1_pt_idx", int'(bus1.pt_idx), 0);
        @(posedge clk); #1;
        check_int("n1_done", int'(bus1.done), 1);
        check_int("n1_valid_after", int'(bus1.out_valid), 0);
        @(posedge clk); #1;
        check_int("n1_idle_busy", int'(bus1.busy), 0);
        check_int("n1_done_once", int'(bus1.done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
